// File: rtl/counter_run_arbiter_if.sv
// Requester-side and counter-side signals of counter_run_arbiter, grouped in one bundle.
// req is a level held by the requester. gnt is one-hot from LOAD through RUN. Dropping req[g] while it is granted aborts the run.
interface counter_run_arbiter_if #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     req_mode;
    logic [WIDTH*NREQ-1:0] req_step;
    logic [WIDTH*NREQ-1:0] req_start;
    logic [WIDTH*NREQ-1:0] req_target;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  timeout_err;
    logic                  busy;
    logic                  ctr_load;
    logic [WIDTH-1:0]      ctr_load_value;
    logic                  ctr_enable;
    logic [1:0]            ctr_mode;
    logic [WIDTH-1:0]      ctr_step_size;
    logic [WIDTH-1:0]      ctr_terminal_value;
    logic                  ctr_terminal_flag;
    logic [1:0]            dbg_state;

    modport master (
        output req, req_mode, req_step, req_start, req_target, ctr_terminal_flag,
        input  gnt, done, timeout_err, busy, ctr_load, ctr_load_value, ctr_enable,
               ctr_mode, ctr_step_size, ctr_terminal_value, dbg_state
    );

    modport slave (
        input  req, req_mode, req_step, req_start, req_target, ctr_terminal_flag,
        output gnt, done, timeout_err, busy, ctr_load, ctr_load_value, ctr_enable,
               ctr_mode, ctr_step_size, ctr_terminal_value, dbg_state
    );
endinterface

// File: rtl/counter_run_arbiter.sv
// Round-robin arbiter that shares one counter among NREQ requesters.
// Each grant is one run: load the start value, then count until the terminal flag, an abort or the watchdog.
module counter_run_arbiter #(
    parameter int WIDTH   = 3,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    counter_run_arbiter_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_step;
    logic [WIDTH-1:0] cfg_start;
    logic [WIDTH-1:0] cfg_target;
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] last;
    logic [TW-1:0]    timer;
    logic             done_pending;
    logic             err_pending;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    logic [1:0]       pick_mode;
    logic [WIDTH-1:0] pick_step;
    logic [WIDTH-1:0] pick_start;
    logic [WIDTH-1:0] pick_target;
    logic [NREQ-1:0]  g_onehot;

    // Search starts one past the last winner, so a requester that has just been served goes to the back of the queue.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = IDX_W'(cand);
            if (!pick_valid && bus.req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        pick_mode   = '0;
        pick_step   = '0;
        pick_start  = '0;
        pick_target = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_mode   = bus.req_mode[2*i +: 2];
                pick_step   = bus.req_step[WIDTH*i +: WIDTH];
                pick_start  = bus.req_start[WIDTH*i +: WIDTH];
                pick_target = bus.req_target[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cfg_mode     <= '0;
            cfg_step     <= '0;
            cfg_start    <= '0;
            cfg_target   <= '0;
            g            <= '0;
            last         <= IDX_W'(NREQ - 1);
            timer        <= '0;
            done_pending <= 1'b0;
            err_pending  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        cfg_mode   <= pick_mode;
                        cfg_step   <= pick_step;
                        cfg_start  <= pick_start;
                        cfg_target <= pick_target;
                        g          <= pick_idx;
                        last       <= pick_idx;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    timer <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (timer != {TW{1'b1}}) timer <= timer + 1'b1;
                    // Terminal beats abort, and abort beats the watchdog.
                    if (bus.ctr_terminal_flag) begin
                        done_pending <= 1'b1;
                        state        <= S_RELEASE;
                    end else if (!bus.req[g]) begin
                        state <= S_RELEASE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        err_pending <= 1'b1;
                        state       <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    done_pending <= 1'b0;
                    err_pending  <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign g_onehot = {{(NREQ-1){1'b0}}, 1'b1} << g;

    // Outputs decode only state and latched registers. ctr_enable is the one exception: it is gated by the terminal flag so the counter stops on the target.
    always_comb begin
        bus.gnt                = '0;
        bus.done               = '0;
        bus.timeout_err        = 1'b0;
        bus.busy               = (state != S_IDLE);
        bus.ctr_load           = 1'b0;
        bus.ctr_load_value     = '0;
        bus.ctr_enable         = 1'b0;
        bus.ctr_mode           = '0;
        bus.ctr_step_size      = '0;
        bus.ctr_terminal_value = '0;
        bus.dbg_state          = state;
        case (state)
            S_LOAD: begin
                bus.gnt            = g_onehot;
                bus.ctr_load       = 1'b1;
                bus.ctr_load_value = cfg_start;
            end
            S_RUN: begin
                bus.gnt                = g_onehot;
                bus.ctr_enable         = ~bus.ctr_terminal_flag;
                bus.ctr_mode           = cfg_mode;
                bus.ctr_step_size      = cfg_step;
                bus.ctr_terminal_value = cfg_target;
            end
            S_RELEASE: begin
                bus.done        = done_pending ? g_onehot : '0;
                bus.timeout_err = err_pending;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/counter_run_arbiter.md
Name: counter_run_arbiter

Overview:
- Shares one `counter` instance among NREQ requesters.
- Each requester asks for a "run": load a start value, then count with its own mode and step until the counter's terminal_flag fires.
- Uses round-robin arbitration, a 4-state Moore FSM and a watchdog timer.
- Sits between software- or FSM-level clients and the counter's load, enable, mode, step and terminal ports.

Parameters:
- WIDTH, 3: counter width; must equal the counter's WIDTH.
- NREQ, 4: number of requesters (≥2).
- TIMEOUT, 16: maximum RUN cycles per grant before the run is aborted.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester run request, level
- req_mode  in  2*NREQ  requester i at [2i+1:2i]; 00 up, 01 down, 10 auto
- req_step  in  WIDTH*NREQ  step size, requester i at [WIDTH*i +: WIDTH]
- req_start  in  WIDTH*NREQ  load value
- req_target  in  WIDTH*NREQ  terminal value
- gnt  out  NREQ  one-hot grant, high from LOAD through RUN
- done  out  NREQ  one-cycle pulse on the served bit when the target is reached
- timeout_err  out  1  one-cycle pulse when a run hits TIMEOUT
- busy  out  1  state != IDLE
- ctr_load  out  1  to counter load
- ctr_load_value  out  WIDTH  to counter load_value
- ctr_enable  out  1  to counter enable
- ctr_mode  out  2  to counter mode
- ctr_step_size  out  WIDTH  to counter step_size
- ctr_terminal_value  out  WIDTH  to counter terminal_value
- ctr_terminal_flag  in  1  from counter terminal_flag

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (sampled at a clk edge with rst_n=0):
  - state=IDLE; all outputs 0.
  - Latched config = 0; timer = 0.
  - RR pointer last=NREQ-1, so requester 0 has top priority first.
  - Reset mid-run abandons the run silently: no done, no err.
- Outputs are Moore-decoded from the state and latched registers; there is no combinational path from req to the outputs.
- IDLE:
  - If any req bit is high, select the first set bit searching last+1, last+2, … modulo NREQ.
  - Latch that requester's mode, step, start and target; set g=index, last=g; go to LOAD.
  - If no req is high, stay in IDLE.
- LOAD (exactly 1 cycle):
  - gnt[g]=1, ctr_load=1, ctr_load_value=start, ctr_enable=0.
  - Go to RUN; timer cleared.
- RUN:
  - gnt[g]=1; ctr_mode, ctr_step_size and ctr_terminal_value driven from the latch; ctr_load=0.
  - ctr_enable = ~ctr_terminal_flag, so the counter never steps past the target.
  - timer increments every RUN cycle, saturating.
  - Exit priority, evaluated each RUN cycle:
    - (1) ctr_terminal_flag=1: go to RELEASE, set done_pending.
    - (2) req[g]=0 (abort): go to RELEASE, no done, no err.
    - (3) timer==TIMEOUT-1: go to RELEASE, set err_pending.
    - Otherwise stay in RUN.
  - The latched config is held even if the req_* buses change.
- RELEASE (exactly 1 cycle):
  - gnt=0, ctr_enable=0.
  - done[g]=done_pending; timeout_err=err_pending.
  - Clear both pending flags; go to IDLE.
- Minimum service time = 4 cycles (IDLE→LOAD→RUN→RELEASE).
  - If start==target, RUN lasts 1 cycle with ctr_enable=0.
- Fairness:
  - A requester holding req after done is re-eligible, but only after every other pending requester has been served once.
  - Two back-to-back runs are separated by one IDLE cycle.
- Mode 11 is passed through unchanged; the counter holds, so the run ends by timeout or abort.
- The counter's own load and enable semantics are unchanged; this block never asserts ctr_load and ctr_enable together.

Test Plan:
1. Basic up run:
   - Stimulus: only req[0], start=2, step=1, mode=00, target=5.
   - Response: LOAD in cycle 1; count=2,3,4,5; terminal seen in cycle 5; done[0] pulse in cycle 6; ctr_enable low in cycle 5; count stays 5.
2. Round-robin:
   - Stimulus: req[0] and req[2] held high; each target is reached in 2 steps.
   - Response: gnt order 0001, 0100, 0001, 0100; each served in turn; never the same bit twice in a row.
3. Timeout:
   - Stimulus: req[1], mode=11, start=1, target=4, TIMEOUT=16.
   - Response: exactly 16 RUN cycles; timeout_err pulse in RELEASE; done=0; count stays 1.
4. Abort:
   - Stimulus: req[3] (down mode, start=6, step=2, target=0) drops in the 2nd RUN cycle.
   - Response: RELEASE next cycle; done=0; timeout_err=0; a pending req[0] is granted after one IDLE cycle.
5. Start equals target:
   - Stimulus: start=target=3.
   - Response: one RUN cycle; ctr_enable never high; done pulse 3 cycles after IDLE exit.
6. Reset mid-run:
   - Stimulus: rst_n=0 for one edge during RUN.
   - Response: next cycle all outputs 0, state IDLE; the next grant goes to the lowest-index pending requester.
